// File: rtl/boa_mem_arbiter_pkg.sv
// Shared widths, request struct and helpers for the data-memory arbiter.
// No logic or latency of its own.
// No backpressure here; this file only defines types.
package boa_mem_arbiter_pkg;

    localparam int BOA_MEM_WE_W   = 4;
    localparam int BOA_MEM_ADDR_W = 30;
    localparam int BOA_MEM_DATA_W = 32;

    typedef struct packed {
        logic                      re;
        logic [BOA_MEM_WE_W-1:0]   we;
        logic [BOA_MEM_ADDR_W-1:0] addr;
        logic [BOA_MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic logic mem_req_valid(input mem_req_t r);
        return r.re || (|r.we);
    endfunction

endpackage

// File: rtl/boa_rr_pick.sv
// Combinational picker: first set req at or after ptr (wrapping), or the lowest set req when FIXED.
// Zero latency.
// No backpressure; any=0 when nothing is requesting.
module boa_rr_pick #(
    parameter int N     = 2,
    parameter bit FIXED = 1'b0
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] sel,
    output logic                 any
);

    localparam int W = $clog2(N);

    logic [W-1:0] start;
    logic [W:0]   cand;

    assign start = FIXED ? '0 : ptr;

    // Walk from the far end back toward start so the nearest hit is the last one written.
    always_comb begin
        sel  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, start} + (W+1)'(k);
            if (cand >= (W+1)'(N)) begin
                cand = cand - (W+1)'(N);
            end
            if (req[cand[W-1:0]]) begin
                sel = cand[W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/boa_mem_arbiter.sv
// Shares one data-memory target between PORTS requesters; grant is held while the target stalls.
// Zero added request latency; read-data valid is steered to the owner one cycle after acceptance.
// Target stall (s_ready=0) locks the current owner and holds m_ready low for everyone.
module boa_mem_arbiter
    import boa_mem_arbiter_pkg::*;
#(
    parameter int PORTS      = 2,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PORTS-1:0]                  m_re,
    input  logic [PORTS*BOA_MEM_WE_W-1:0]     m_we,
    input  logic [PORTS*BOA_MEM_ADDR_W-1:0]   m_addr,
    input  logic [PORTS*BOA_MEM_DATA_W-1:0]   m_wdata,
    output logic [PORTS-1:0]                  m_ready,
    output logic [BOA_MEM_DATA_W-1:0]         m_rdata,
    output logic [PORTS-1:0]                  m_rvalid,
    output logic                              s_re,
    output logic [BOA_MEM_WE_W-1:0]           s_we,
    output logic [BOA_MEM_ADDR_W-1:0]         s_addr,
    output logic [BOA_MEM_DATA_W-1:0]         s_wdata,
    input  logic                              s_ready,
    input  logic [BOA_MEM_DATA_W-1:0]         s_rdata
);

    localparam int IDX_W = $clog2(PORTS);

    mem_req_t         port_req [PORTS];
    mem_req_t         fwd;
    logic [PORTS-1:0] req;

    logic             lock;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic             resp_valid;
    logic [IDX_W-1:0] resp_owner;

    logic [IDX_W-1:0] pick_sel;
    logic             pick_any;
    logic [IDX_W-1:0] sel;
    logic             active;
    logic             accept;
    logic [IDX_W-1:0] next_ptr;

    for (genvar i = 0; i < PORTS; i++) begin : g_port
        assign port_req[i] = '{re:    m_re[i],
                               we:    m_we[i*BOA_MEM_WE_W +: BOA_MEM_WE_W],
                               addr:  m_addr[i*BOA_MEM_ADDR_W +: BOA_MEM_ADDR_W],
                               wdata: m_wdata[i*BOA_MEM_DATA_W +: BOA_MEM_DATA_W]};
        assign req[i]      = mem_req_valid(port_req[i]);
    end

    boa_rr_pick #(
        .N     (PORTS),
        .FIXED (FIXED_PRIO)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .sel (pick_sel),
        .any (pick_any)
    );

    // A locked owner that drops its request yields an idle cycle, not a grant to someone else.
    assign sel      = lock ? owner : pick_sel;
    assign active   = !rst && (lock ? req[owner] : pick_any);
    assign accept   = active && s_ready;
    assign next_ptr = (sel == IDX_W'(PORTS - 1)) ? '0 : sel + IDX_W'(1);

    assign fwd     = active ? port_req[sel] : '0;
    assign s_re    = fwd.re;
    assign s_we    = fwd.we;
    assign s_addr  = fwd.addr;
    assign s_wdata = fwd.wdata;
    assign m_rdata = s_rdata;

    always_comb begin
        m_ready  = '0;
        m_rvalid = '0;
        for (int i = 0; i < PORTS; i++) begin
            m_ready[i]  = accept && (sel == IDX_W'(i));
            m_rvalid[i] = resp_valid && !rst && (resp_owner == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock       <= 1'b0;
            owner      <= '0;
            rr_ptr     <= '0;
            resp_valid <= 1'b0;
            resp_owner <= '0;
        end else if (active && !s_ready) begin
            lock       <= 1'b1;
            owner      <= sel;
            resp_valid <= 1'b0;
        end else if (accept) begin
            lock       <= 1'b0;
            rr_ptr     <= next_ptr;
            resp_owner <= sel;
            resp_valid <= m_re[sel];
        end else begin
            lock       <= 1'b0;
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_boa_mem_arbiter.sv
// Directed bench: a 2-port round-robin arbiter and a 3-port fixed-priority arbiter,
// driven one cycle at a time and compared against hand-derived values.
module tb_boa_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 2-port round-robin instance
    logic [1:0]  m_re;
    logic [7:0]  m_we;
    logic [59:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_ready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rvalid;
    logic        s_re;
    logic [3:0]  s_we;
    logic [29:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_ready;
    logic [31:0] s_rdata;

    // 3-port fixed-priority instance
    logic [2:0]  f_re;
    logic [11:0] f_we;
    logic [89:0] f_addr;
    logic [95:0] f_wdata;
    logic [2:0]  f_ready;
    logic [31:0] f_rdata;
    logic [2:0]  f_rvalid;
    logic        f_s_re;
    logic [3:0]  f_s_we;
    logic [29:0] f_s_addr;
    logic [31:0] f_s_wdata;
    logic        f_s_ready;
    logic [31:0] f_s_rdata;

    int n_cmp = 0;
    int n_err = 0;

    boa_mem_arbiter #(.PORTS(2), .FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
        .s_re(s_re), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata)
    );

    boa_mem_arbiter #(.PORTS(3), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst(rst),
        .m_re(f_re), .m_we(f_we), .m_addr(f_addr), .m_wdata(f_wdata),
        .m_ready(f_ready), .m_rdata(f_rdata), .m_rvalid(f_rvalid),
        .s_re(f_s_re), .s_we(f_s_we), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
        .s_ready(f_s_ready), .s_rdata(f_s_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_p(input int p, input logic re, input logic [3:0] we,
                         input logic [29:0] addr, input logic [31:0] wdata);
        m_re[p]             = re;
        m_we[4*p +: 4]      = we;
        m_addr[30*p +: 30]  = addr;
        m_wdata[32*p +: 32] = wdata;
    endtask

    task automatic idle_all();
        m_re = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    endtask

    // Inputs change just after a rising edge; checks follow 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        s_ready = 1'b1; s_rdata = '0;
        f_re = '0; f_we = '0; f_addr = '0; f_wdata = '0;
        f_s_ready = 1'b1; f_s_rdata = '0;

        // Reset cycle: a live request must not leak out
        set_p(0, 1'b1, 4'h0, 30'h100, 32'h0);
        #1;
        chk("rst_m_ready", m_ready, 2'b00);
        chk("rst_s_re", s_re, 1'b0);
        chk("rst_s_we", s_we, 4'h0);
        chk("rst_m_rvalid", m_rvalid, 2'b00);
        tick();
        rst = 1'b0;

        // Single read
        #1;
        chk("rd_m_ready", m_ready, 2'b01);
        chk("rd_s_addr", s_addr, 30'h100);
        chk("rd_s_re", s_re, 1'b1);
        tick();
        idle_all(); s_rdata = 32'hDEADBEEF;
        #1;
        chk("rd_m_rvalid", m_rvalid, 2'b01);
        chk("rd_m_rdata", m_rdata, 32'hDEADBEEF);
        chk("rd_idle_s_re", s_re, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Contention, round-robin from rr_ptr=0: grants 0,1,0,1
        set_p(0, 1'b1, 4'h0, 30'h10, 32'h0);
        set_p(1, 1'b1, 4'h0, 30'h20, 32'h0);
        #1;
        chk("rr0_m_ready", m_ready, 2'b01);
        chk("rr0_s_addr", s_addr, 30'h10);
        tick();
        chk("rr1_m_ready", m_ready, 2'b10);
        chk("rr1_s_addr", s_addr, 30'h20);
        chk("rr1_m_rvalid", m_rvalid, 2'b01);
        tick();
        chk("rr2_m_ready", m_ready, 2'b01);
        chk("rr2_m_rvalid", m_rvalid, 2'b10);
        tick();
        chk("rr3_m_ready", m_ready, 2'b10);
        chk("rr3_m_rvalid", m_rvalid, 2'b01);
        tick();
        idle_all();
        #1;
        chk("rr4_m_rvalid", m_rvalid, 2'b10);
        chk("rr4_m_ready", m_ready, 2'b00);
        tick();

        // Stall lock: port1 write held while port0 waits
        s_ready = 1'b0;
        set_p(1, 1'b0, 4'b0011, 30'h30, 32'hCAFE0001);
        #1;
        chk("stl0_s_we", s_we, 4'b0011);
        chk("stl0_s_addr", s_addr, 30'h30);
        chk("stl0_m_ready", m_ready, 2'b00);
        tick();
        set_p(0, 1'b1, 4'h0, 30'h40, 32'h0);
        #1;
        chk("stl1_s_addr", s_addr, 30'h30);
        chk("stl1_m_ready", m_ready, 2'b00);
        tick();
        chk("stl2_s_we", s_we, 4'b0011);
        chk("stl2_s_re", s_re, 1'b0);
        chk("stl2_m_ready", m_ready, 2'b00);
        tick();
        s_ready = 1'b1;
        #1;
        chk("stl3_m_ready", m_ready, 2'b10);
        chk("stl3_s_wdata", s_wdata, 32'hCAFE0001);
        tick();
        set_p(1, 1'b0, 4'h0, 30'h0, 32'h0);
        #1;
        chk("stl4_m_ready", m_ready, 2'b01);
        chk("stl4_s_addr", s_addr, 30'h40);
        chk("stl4_wr_no_rvalid", m_rvalid, 2'b00);
        tick();
        idle_all();
        #1;
        chk("stl5_m_rvalid", m_rvalid, 2'b01);
        tick();

        // Abandoned lock: port0 stalls then withdraws while port1 asks
        s_ready = 1'b0;
        set_p(0, 1'b1, 4'h0, 30'h50, 32'h0);
        #1;
        chk("ab1_s_re", s_re, 1'b1);
        chk("ab1_m_ready", m_ready, 2'b00);
        tick();
        s_ready = 1'b1;
        set_p(0, 1'b0, 4'h0, 30'h0, 32'h0);
        set_p(1, 1'b1, 4'h0, 30'h60, 32'h0);
        #1;
        chk("ab2_s_re", s_re, 1'b0);
        chk("ab2_s_we", s_we, 4'h0);
        chk("ab2_m_ready", m_ready, 2'b00);
        tick();
        chk("ab3_m_ready", m_ready, 2'b10);
        chk("ab3_s_addr", s_addr, 30'h60);
        chk("ab3_m_rvalid", m_rvalid, 2'b00);
        tick();
        idle_all();
        #1;
        chk("ab4_m_rvalid", m_rvalid, 2'b10);
        tick();

        // Reset the cycle after an accepted read
        set_p(0, 1'b1, 4'h0, 30'h70, 32'h0);
        #1;
        chk("rmr0_m_ready", m_ready, 2'b01);
        tick();
        idle_all();
        rst = 1'b1;
        #1;
        chk("rmr1_m_rvalid", m_rvalid, 2'b00);
        chk("rmr1_m_ready", m_ready, 2'b00);
        tick();
        rst = 1'b0;
        set_p(0, 1'b1, 4'h0, 30'h80, 32'h0);
        set_p(1, 1'b1, 4'h0, 30'h90, 32'h0);
        #1;
        chk("rmr2_ptr0_grant", m_ready, 2'b01);
        chk("rmr2_m_rvalid", m_rvalid, 2'b00);
        tick();
        idle_all();

        // Fixed priority, 3 ports, all requesting
        f_re = 3'b111;
        f_addr = {30'h3, 30'h2, 30'h1};
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("fp%0d_m_ready", c), f_ready, 3'b001);
            chk($sformatf("fp%0d_s_addr", c), f_s_addr, 30'h1);
            tick();
        end
        f_re = 3'b110;
        #1;
        chk("fp_drop0_m_ready", f_ready, 3'b010);
        chk("fp_drop0_s_addr", f_s_addr, 30'h2);
        tick();
        f_re = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
